sevenseg_scan: RTL and testbench
================================

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 The block SHALL provide parameter CLK_DIV, default 100000, giving clocks per digit slot; legal range 16..2^20.
REQ-002 The block SHALL provide these ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- digit3, digit2, digit1, digit0  in  4 each  hex nibbles from the GPIO memory block; digit3 is the leftmost digit.
- blank_lz  in  1  leading-zero blanking enable.
- dp_mask  in  4  decimal-point enables; bit i belongs to digit i.
- brightness  in  4  duty level 0..15.
- an  out  4  anodes, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-003 The prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; slot_tick SHALL be asserted when the count equals CLK_DIV-1.
REQ-004 The 2-bit digit index SHALL advance on slot_tick (0->1->2->3->0).
REQ-005 On the 3->0 wrap, frame_done SHALL pulse high for exactly one cycle.
REQ-006 On that same edge, shadow registers SHALL capture digit3..digit0, blank_lz, dp_mask and brightness.
REQ-007 Input changes at any other time SHALL NOT affect the display until the next frame boundary (no tearing).
REQ-008 A 4-bit PWM counter SHALL increment every clock and wrap 15->0.
REQ-009 The selected anode SHALL be enabled only while pwm_cnt <= shadow brightness: 15 gives 100% duty, 0 gives 1/16 duty.
REQ-010 Index i SHALL select anode bit i: index 0 gives an=4'b1110, index 3 gives an=4'b0111.
REQ-011 Non-selected anodes SHALL be 1.
REQ-012 Hex decode (seg value in hex) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-013 When shadow blank_lz=1, leading zeros SHALL be blanked:
- digit3 blanked if d3=0.
- digit2 blanked if d3=d2=0.
- digit1 blanked if d3=d2=d1=0.
- digit0 never blanked.
REQ-014 A blanked digit SHALL drive seg=7F.
REQ-015 A blanked digit's anode SHALL be enabled only if its dp_mask bit is 1, so the point stays visible.
REQ-016 dp SHALL be 0 when the selected digit's shadow dp_mask bit is 1 and the anode is enabled; otherwise dp SHALL be 1.
REQ-017 an, seg and dp SHALL be registered, reflecting index, PWM and shadow state with exactly one clock of latency.
REQ-018 While an=4'b1111 (PWM off phase), seg SHALL be 7F and dp SHALL be 1 to prevent ghosting.

Reset
REQ-019 While reset=1 at a clock edge, the block SHALL set:
- prescaler, index and pwm_cnt to 0.
- all shadow registers to 0.
- an=4'b1111, seg=7F, dp=1, frame_done=0.
REQ-020 Reset asserted mid-slot or mid-frame SHALL abort the scan; on the first edge after reset deasserts, scanning SHALL restart at index 0.
REQ-021 No frame_done pulse SHALL occur during reset or on the first edge after reset deasserts.
REQ-022 Immediately after reset, before the first frame boundary, the block SHALL display shadow values: all digits "0", brightness 0.

Verification (CLK_DIV=16 for simulation)
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then wait 64 cycles with digits=1,2,3,4 and brightness=15 -> frame_done pulses at cycle 64. After the next frame, slot 0 shows an=1110, seg=19; slot 3 shows an=0111, seg=79.
- digit inputs change at cycle 10 of a frame -> an/seg unchanged until frame_done, then new values appear one cycle later.
- blank_lz=1, digits=0,0,0,7 -> an never 0111, 1011 or 1101; slot 0 shows seg=78.
- blank_lz=1, digits=0,0,0,0 -> digit0 shows seg=40.
- brightness=0, digits=8,8,8,8 -> within each slot the anode is low for 1 of every 16 cycles with seg=00, and seg=7F otherwise.
- brightness=7 -> the anode is low for 8 of every 16 cycles.
- dp_mask=4'b0100, blank_lz=1, digits=0,0,5,0 -> in slot 2: an=1011, seg=7F, dp=0. Slot 1 shows seg=12, dp=1.
- reset pulsed during slot 2 -> next edge: an=1111, seg=7F, frame_done=0. After release, slot 0 is active for 16 cycles, and frame_done first fires 64 cycles after release.

Source files
------------

// File: rtl/sevenseg_scan.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous shadowing,
// leading-zero blanking, per-digit decimal points and PWM brightness control.
module sevenseg_scan #(
  parameter int CLK_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  input  logic       blank_lz,
  input  logic [3:0] dp_mask,
  input  logic [3:0] brightness,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done,
  output logic [1:0] dbg_slot
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_t;

  slot_t          state;
  slot_t          state_next;
  logic [PW-1:0]  presc;
  logic           slot_tick;
  logic [1:0]     slot_idx;
  logic [3:0]     anode_sel;
  logic           frame_wrap;
  logic [3:0]     pwm_cnt;

  logic [3:0][3:0] sh_digits;
  logic            sh_blank_lz;
  logic [3:0]      sh_dp_mask;
  logic [3:0]      sh_brightness;

  logic [3:0] cur_digit;
  logic       lz3;
  logic       lz2;
  logic       lz1;
  logic       blanked;
  logic       dp_sel;
  logic       pwm_on;
  logic       anode_en;
  logic [6:0] seg_dec;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  assign slot_tick = (presc == PRESC_MAX);
  assign dbg_slot  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (slot_tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  // Scan FSM: one state per digit slot, advancing on each prescaler wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SLOT0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (slot_tick) begin
      case (state)
        SLOT0:   state_next = SLOT1;
        SLOT1:   state_next = SLOT2;
        SLOT2:   state_next = SLOT3;
        SLOT3:   state_next = SLOT0;
        default: state_next = SLOT0;
      endcase
    end
  end

  always_comb begin
    slot_idx   = 2'd0;
    anode_sel  = 4'b1110;
    frame_wrap = 1'b0;
    case (state)
      SLOT0: begin
        slot_idx  = 2'd0;
        anode_sel = 4'b1110;
      end
      SLOT1: begin
        slot_idx  = 2'd1;
        anode_sel = 4'b1101;
      end
      SLOT2: begin
        slot_idx  = 2'd2;
        anode_sel = 4'b1011;
      end
      SLOT3: begin
        slot_idx   = 2'd3;
        anode_sel  = 4'b0111;
        frame_wrap = slot_tick;
      end
      default: begin
        slot_idx  = 2'd0;
        anode_sel = 4'b1110;
      end
    endcase
  end

  // Display settings only move at the frame boundary so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_digits     <= '0;
      sh_blank_lz   <= 1'b0;
      sh_dp_mask    <= 4'd0;
      sh_brightness <= 4'd0;
    end else if (frame_wrap) begin
      sh_digits     <= {digit3, digit2, digit1, digit0};
      sh_blank_lz   <= blank_lz;
      sh_dp_mask    <= dp_mask;
      sh_brightness <= brightness;
    end
  end

  assign cur_digit = sh_digits[slot_idx];
  assign dp_sel    = sh_dp_mask[slot_idx];
  assign lz3       = (sh_digits[3] == 4'd0);
  assign lz2       = lz3 && (sh_digits[2] == 4'd0);
  assign lz1       = lz2 && (sh_digits[1] == 4'd0);

  always_comb begin
    blanked = 1'b0;
    case (slot_idx)
      2'd3:    blanked = sh_blank_lz && lz3;
      2'd2:    blanked = sh_blank_lz && lz2;
      2'd1:    blanked = sh_blank_lz && lz1;
      default: blanked = 1'b0;
    endcase
  end

  always_comb begin
    seg_dec = 7'h7F;
    case (cur_digit)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase
  end

  // A blanked digit keeps its anode lit only to show its decimal point.
  assign pwm_on   = (pwm_cnt <= sh_brightness);
  assign anode_en = pwm_on && (!blanked || dp_sel);

  always_comb begin
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (anode_en) begin
      an_d  = anode_sel;
      seg_d = blanked ? 7'h7F : seg_dec;
      dp_d  = !dp_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: directed scenarios plus random input churn, all
// checked every cycle against a cycle-count based reference model.
module tb_sevenseg_scan;

  localparam int P = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit3 = 4'd0;
  logic [3:0] digit2 = 4'd0;
  logic [3:0] digit1 = 4'd0;
  logic [3:0] digit0 = 4'd0;
  logic       blank_lz = 1'b0;
  logic [3:0] dp_mask = 4'd0;
  logic [3:0] brightness = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;
  logic [1:0] dbg_slot;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state: edges since reset plus the frame-latched settings.
  int         k = 0;
  logic [3:0] m_d [4];
  logic       m_blz = 1'b0;
  logic [3:0] m_dpm = 4'd0;
  logic [3:0] m_br = 4'd0;
  logic [3:0] e_an = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp = 1'b1;
  logic       e_fd = 1'b0;
  bit         model_valid = 1'b0;

  logic [3:0] o_an  [64];
  logic [6:0] o_seg [64];
  logic       o_dp  [64];

  sevenseg_scan #(.CLK_DIV(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .digit3     (digit3),
    .digit2     (digit2),
    .digit1     (digit1),
    .digit0     (digit0),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .brightness (brightness),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done),
    .dbg_slot   (dbg_slot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int  idx;
    int  pwm;
    bit  lead;
    bit  blanked;
    bit  on;
    if (reset) begin
      k = 0;
      for (int j = 0; j < 4; j++) m_d[j] = 4'd0;
      m_blz = 1'b0;
      m_dpm = 4'd0;
      m_br  = 4'd0;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_fd  = 1'b0;
      model_valid = 1'b1;
    end else begin
      idx  = (k / P) % 4;
      pwm  = k % 16;
      lead = 1'b1;
      for (int j = idx; j < 4; j++) if (m_d[j] != 4'd0) lead = 1'b0;
      blanked = m_blz && (idx != 0) && lead;
      on      = (pwm <= int'(m_br)) && (!blanked || m_dpm[idx]);
      e_an    = on ? ~(4'b0001 << idx) : 4'hF;
      e_seg   = (on && !blanked) ? seg_tab[m_d[idx]] : 7'h7F;
      e_dp    = !(on && m_dpm[idx]);
      e_fd    = (k % (4 * P)) == (4 * P - 1);
      if (e_fd) begin
        m_d[3] = digit3;
        m_d[2] = digit2;
        m_d[1] = digit1;
        m_d[0] = digit0;
        m_blz  = blank_lz;
        m_dpm  = dp_mask;
        m_br   = brightness;
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (model_valid)
      check("scan_out{an,seg,dp,fd}", {an, seg, dp, frame_done}, {e_an, e_seg, e_dp, e_fd});
  end

  task automatic drive(input logic [3:0] a3, input logic [3:0] a2, input logic [3:0] a1,
                       input logic [3:0] a0, input logic blz, input logic [3:0] dpm,
                       input logic [3:0] br);
    digit3 = a3;
    digit2 = a2;
    digit1 = a1;
    digit0 = a0;
    blank_lz = blz;
    dp_mask = dpm;
    brightness = br;
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 300);
    if (!frame_done) check("frame_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic observe_frame();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      o_an[i]  = an;
      o_seg[i] = seg;
      o_dp[i]  = dp;
    end
  endtask

  task automatic run(input logic [3:0] a3, input logic [3:0] a2, input logic [3:0] a1,
                     input logic [3:0] a0, input logic blz, input logic [3:0] dpm,
                     input logic [3:0] br);
    int n;
    drive(a3, a2, a1, a0, blz, dpm, br);
    wait_fd(n);
    observe_frame();
  endtask

  function automatic int count_on(input int first, input int last);
    int c = 0;
    for (int i = first; i <= last; i++) if (o_an[i] != 4'hF) c++;
    return c;
  endfunction

  initial begin
    int n;
    int c;
    int fd_first;
    logic [3:0] r_an [65];
    logic [6:0] r_seg [65];

    drive(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4'd0, 4'd15);
    repeat (3) @(negedge clk);
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    check("reset_fd", frame_done, 1'b0);
    reset = 1'b0;

    wait_fd(n);
    check("first_fd_cycle", n, 64);
    observe_frame();
    check("s0_an_1234", o_an[0], 4'b1110);
    check("s0_seg_1234", o_seg[0], 7'h19);
    check("s3_an_1234", o_an[48], 4'b0111);
    check("s3_seg_1234", o_seg[48], 7'h79);

    repeat (10) @(negedge clk);
    drive(4'h9, 4'hA, 4'hB, 4'hC, 1'b0, 4'd0, 4'd15);
    wait_fd(n);
    check("tear_fd_wait", n, 54);
    check("tear_old_an", an, 4'b0111);
    check("tear_old_seg", seg, 7'h79);
    @(negedge clk);
    check("tear_new_an", an, 4'b1110);
    check("tear_new_seg", seg, 7'h46);

    run(4'd0, 4'd0, 4'd0, 4'd7, 1'b1, 4'd0, 4'd15);
    c = 0;
    for (int i = 0; i < 64; i++)
      if (o_an[i] == 4'b0111 || o_an[i] == 4'b1011 || o_an[i] == 4'b1101) c++;
    check("lz0007_blanked_anodes", c, 0);
    check("lz0007_s0_seg", o_seg[0], 7'h78);

    run(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd0, 4'd15);
    check("lz0000_s0_seg", o_seg[0], 7'h40);
    check("lz0000_upper_dark", count_on(16, 63), 0);

    run(4'd8, 4'd8, 4'd8, 4'd8, 1'b0, 4'd0, 4'd0);
    check("br0_s0_on", count_on(0, 15), 1);
    check("br0_s0_an", o_an[0], 4'b1110);
    check("br0_s0_seg", o_seg[0], 7'h00);
    c = 0;
    for (int i = 0; i < 16; i++) if (o_seg[i] == 7'h7F) c++;
    check("br0_s0_dark_seg", c, 15);
    check("br0_s2_on", count_on(32, 47), 1);

    run(4'd8, 4'd8, 4'd8, 4'd8, 1'b0, 4'd0, 4'd7);
    check("br7_s1_on", count_on(16, 31), 8);
    check("br7_s1_last_on", o_an[23], 4'b1101);
    check("br7_s1_first_off", o_an[24], 4'hF);

    run(4'd0, 4'd0, 4'd5, 4'd0, 1'b1, 4'b0100, 4'd15);
    check("dp_s2_an", o_an[32], 4'b1011);
    check("dp_s2_seg", o_seg[32], 7'h7F);
    check("dp_s2_dp", o_dp[32], 1'b0);
    check("dp_s1_seg", o_seg[16], 7'h12);
    check("dp_s1_dp", o_dp[16], 1'b1);
    check("dp_s3_an", o_an[48], 4'hF);

    drive(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd15);
    repeat (37) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_an", an, 4'hF);
    check("midreset_seg", seg, 7'h7F);
    check("midreset_dp", dp, 1'b1);
    check("midreset_fd", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fd_first = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      r_an[i]  = an;
      r_seg[i] = seg;
      if (frame_done && fd_first == 0) fd_first = i;
    end
    check("rel_s0_an", r_an[1], 4'b1110);
    check("rel_s0_seg", r_seg[1], 7'h40);
    c = 0;
    for (int i = 2; i <= 16; i++) if (r_an[i] != 4'hF) c++;
    check("rel_s0_dark", c, 0);
    check("rel_s1_an", r_an[17], 4'b1101);
    check("rel_fd_first", fd_first, 64);

    for (int t = 0; t < 1200; t++) begin
      @(negedge clk);
      if ($urandom_range(19, 0) == 0)
        drive(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
              4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
              4'($urandom_range(15, 0)));
      reset = ($urandom_range(399, 0) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (70) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
